// File: rtl/wb_retire_queue_pkg.sv
// Shared definitions for the write-back retire queue: write-enable lane
// constants and the MEM->WB bus layout {gr_we[3:0], dest, result, pc}, MSB first.
// Optional forwarding is enabled with the WB_FWD_EN macro.
package wb_retire_queue_pkg;

  localparam int WE_W = 4;
  localparam logic [WE_W-1:0] WE_FULL = 4'hF;
  localparam logic [WE_W-1:0] WE_NONE = 4'h0;

  // Total MEM->WB bus width.
  function automatic int ws_q_bus_wd(input int aw, input int dw, input int pw);
    return WE_W + aw + dw + pw;
  endfunction

  // Bus field offsets; pc sits at bit 0.
  function automatic int off_result(input int pw);
    return pw;
  endfunction

  function automatic int off_dest(input int dw, input int pw);
    return pw + dw;
  endfunction

  function automatic int off_we(input int aw, input int dw, input int pw);
    return pw + dw + aw;
  endfunction

endpackage

// File: rtl/wb_retire_queue_if.sv
// MEM->WB handshake and register-file write port bundle.
// slave: the retire queue; master: MEM stage plus RF arbiter side.
interface wb_retire_queue_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int AW     = 5
);
  import wb_retire_queue_pkg::*;

  localparam int BUS_W = ws_q_bus_wd(AW, DATA_W, PC_W);

  logic              ms_to_ws_valid;
  logic [BUS_W-1:0]  ms_to_ws_bus;
  logic              ws_allowin;
  logic [WE_W-1:0]   rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;

  modport master (
    output ms_to_ws_valid, ms_to_ws_bus, rf_ready,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  ms_to_ws_valid, ms_to_ws_bus, rf_ready,
    output ws_allowin, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_hazard_match.sv
// One decode query against all queued entries, presented oldest (index 0)
// to youngest. Hit is an OR over every pending write; with WB_FWD_EN the
// youngest match is selected and forwarded only when it writes all lanes.
module wb_hazard_match
  import wb_retire_queue_pkg::*;
#(
`ifdef WB_FWD_EN
  parameter int DATA_W = 32,
`endif
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic [AW-1:0]         raddr,
  input  logic [DEPTH-1:0]      ent_valid,
  input  logic [DEPTH*WE_W-1:0] ent_we,
  input  logic [DEPTH*AW-1:0]   ent_dest,
`ifdef WB_FWD_EN
  input  logic [DEPTH*DATA_W-1:0] ent_res,
  output logic                    fwd_ok,
  output logic [DATA_W-1:0]       fwd_data,
`endif
  output logic                  hit
);

`ifdef WB_FWD_EN
  logic [WE_W-1:0] sel_we;
`endif

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit = 1'b0;
`ifdef WB_FWD_EN
    sel_we   = WE_NONE;
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && (ent_we[k*WE_W +: WE_W] != WE_NONE) &&
          (ent_dest[k*AW +: AW] == raddr) && (raddr != '0)) begin
        hit = 1'b1;
`ifdef WB_FWD_EN
        sel_we   = ent_we[k*WE_W +: WE_W];
        fwd_data = ent_res[k*DATA_W +: DATA_W];
`endif
      end
    end
`ifdef WB_FWD_EN
    fwd_ok = hit && (sel_we == WE_FULL);
`endif
  end

endmodule

// File: rtl/wb_retire_queue.sv
// Write-back retire queue: DEPTH-entry in-order circular buffer between MEM
// and the RF write port. Absorbs rf_ready back-pressure, answers NQ decode
// hazard queries over every queued entry and drives the trace port from the
// retiring entry. Define WB_FWD_EN to add full-word forwarding outputs.
module wb_retire_queue
  import wb_retire_queue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int AW     = 5,
  parameter int DEPTH  = 2,
  parameter int NQ     = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  wb_retire_queue_if.slave     wb,
  input  logic [NQ*AW-1:0]     id_raddr,
  output logic [NQ-1:0]        id_hit,
`ifdef WB_FWD_EN
  output logic [NQ-1:0]        id_fwd_ok,
  output logic [NQ*DATA_W-1:0] id_fwd_data,
`endif
  output logic                 ws_empty,
  output logic [PC_W-1:0]      debug_wb_pc,
  output logic [WE_W-1:0]      debug_wb_rf_wen,
  output logic [AW-1:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam int OFF_RES  = off_result(PC_W);
  localparam int OFF_DEST = off_dest(DATA_W, PC_W);
  localparam int OFF_WE   = off_we(AW, DATA_W, PC_W);

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  valid_q;
  logic [WE_W-1:0]   we_q   [DEPTH];
  logic [AW-1:0]     dest_q [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];

  logic            head_valid;
  logic [WE_W-1:0] head_we;
  logic            push, pop;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = valid_q[head_q];
  assign head_we    = we_q[head_q];

  // Lane-less entries retire without waiting for the shared RF port.
  assign pop           = head_valid && (wb.rf_ready || (head_we == WE_NONE));
  assign wb.ws_allowin = (count_q < DEPTH_C) || pop;
  assign push          = wb.ms_to_ws_valid && wb.ws_allowin;

  assign wb.rf_we    = head_we & {WE_W{head_valid}};
  assign wb.rf_waddr = dest_q[head_q];
  assign wb.rf_wdata = res_q[head_q];
  assign ws_empty    = (count_q == '0);

  assign debug_wb_pc       = pc_q[head_q];
  assign debug_wb_rf_wen   = pop ? wb.rf_we : WE_NONE;
  assign debug_wb_rf_wnum  = dest_q[head_q];
  assign debug_wb_rf_wdata = res_q[head_q];

  // Pointers, occupancy and valid bits; a push into the slot popped the same
  // cycle (full queue) must leave it valid, so the push update comes last.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_inc(tail_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload capture; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      we_q[tail_q]   <= wb.ms_to_ws_bus[OFF_WE +: WE_W];
      dest_q[tail_q] <= wb.ms_to_ws_bus[OFF_DEST +: AW];
      res_q[tail_q]  <= wb.ms_to_ws_bus[OFF_RES +: DATA_W];
      pc_q[tail_q]   <= wb.ms_to_ws_bus[PC_W-1:0];
    end
  end

  logic [DEPTH-1:0]        age_valid;
  logic [DEPTH*WE_W-1:0]   age_we;
  logic [DEPTH*AW-1:0]     age_dest;
`ifdef WB_FWD_EN
  logic [DEPTH*DATA_W-1:0] age_res;
`endif

  // Rotate storage into age order (head first) for the hazard scan.
  always_comb begin
    age_valid = '0;
    age_we    = '0;
    age_dest  = '0;
`ifdef WB_FWD_EN
    age_res   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      int idx;
      idx = int'(head_q) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      age_valid[k]              = valid_q[PTR_W'(idx)];
      age_we[k*WE_W +: WE_W]    = we_q[PTR_W'(idx)];
      age_dest[k*AW +: AW]      = dest_q[PTR_W'(idx)];
`ifdef WB_FWD_EN
      age_res[k*DATA_W +: DATA_W] = res_q[PTR_W'(idx)];
`endif
    end
  end

  for (genvar q = 0; q < NQ; q++) begin : g_query
    wb_hazard_match #(
`ifdef WB_FWD_EN
      .DATA_W   (DATA_W),
`endif
      .AW       (AW),
      .DEPTH    (DEPTH)
    ) u_match (
      .raddr    (id_raddr[q*AW +: AW]),
      .ent_valid(age_valid),
      .ent_we   (age_we),
      .ent_dest (age_dest),
`ifdef WB_FWD_EN
      .ent_res  (age_res),
      .fwd_ok   (id_fwd_ok[q]),
      .fwd_data (id_fwd_data[q*DATA_W +: DATA_W]),
`endif
      .hit      (id_hit[q])
    );
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue (DEPTH=2, NQ=2). Forwarding checks are
// compiled in when WB_FWD_EN is defined.
module tb_wb_retire_queue;
  import wb_retire_queue_pkg::*;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int AW     = 5;
  localparam int DEPTH  = 2;
  localparam int NQ     = 2;

  logic clk;
  logic resetn;
  logic [NQ*AW-1:0]  id_raddr;
  logic [NQ-1:0]     id_hit;
`ifdef WB_FWD_EN
  logic [NQ-1:0]        id_fwd_ok;
  logic [NQ*DATA_W-1:0] id_fwd_data;
`endif
  logic              ws_empty;
  logic [PC_W-1:0]   debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [AW-1:0]     debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;

  int n_cmp = 0;
  int n_err = 0;

  wb_retire_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .AW(AW)) wb_if ();

  wb_retire_queue #(
    .DATA_W(DATA_W), .PC_W(PC_W), .AW(AW), .DEPTH(DEPTH), .NQ(NQ)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .wb               (wb_if),
    .id_raddr         (id_raddr),
    .id_hit           (id_hit),
`ifdef WB_FWD_EN
    .id_fwd_ok        (id_fwd_ok),
    .id_fwd_data      (id_fwd_data),
`endif
    .ws_empty         (ws_empty),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [3:0] we, input logic [AW-1:0] dest,
                            input logic [DATA_W-1:0] res, input logic [PC_W-1:0] pc);
    wb_if.ms_to_ws_valid = 1'b1;
    wb_if.ms_to_ws_bus   = {we, dest, res, pc};
  endtask

  initial begin
    resetn               = 1'b1;
    wb_if.ms_to_ws_valid = 1'b0;
    wb_if.ms_to_ws_bus   = '0;
    wb_if.rf_ready       = 1'b0;
    id_raddr             = '0;
    #1 resetn = 1'b0;
    #1;
    check_val("rst_rf_we",   64'(wb_if.rf_we), 64'h0);
    check_val("rst_id_hit",  64'(id_hit), 64'h0);
    check_val("rst_empty",   64'(ws_empty), 64'h1);
    check_val("rst_dbg_wen", 64'(debug_wb_rf_wen), 64'h0);
    check_val("rst_allowin", 64'(wb_if.ws_allowin), 64'h1);
    tick();
    tick();
    resetn = 1'b1;

    // Single entry, RF ready: writes one edge after the push.
    wb_if.rf_ready = 1'b1;
    drive_push(4'hF, 5'd3, 32'hDEADBEEF, 32'hBFC00000);
    #1 check_val("t1_allowin", 64'(wb_if.ws_allowin), 64'h1);
    tick();
    wb_if.ms_to_ws_valid = 1'b0;
    #1;
    check_val("t1_rf_we",    64'(wb_if.rf_we), 64'hF);
    check_val("t1_waddr",    64'(wb_if.rf_waddr), 64'd3);
    check_val("t1_wdata",    64'(wb_if.rf_wdata), 64'hDEADBEEF);
    check_val("t1_dbg_pc",   64'(debug_wb_pc), 64'hBFC00000);
    check_val("t1_dbg_wen",  64'(debug_wb_rf_wen), 64'hF);
    check_val("t1_dbg_wnum", 64'(debug_wb_rf_wnum), 64'd3);
    tick();
    check_val("t1_empty",    64'(ws_empty), 64'h1);
    check_val("t1_rf_we0",   64'(wb_if.rf_we), 64'h0);

    // Back-pressure: fill, third push waits, then accepted alongside first pop.
    wb_if.rf_ready = 1'b0;
    drive_push(4'hF, 5'd1, 32'h11, 32'h10);
    tick();
    drive_push(4'hF, 5'd2, 32'h22, 32'h14);
    #1 check_val("t2_allowin1", 64'(wb_if.ws_allowin), 64'h1);
    tick();
    drive_push(4'hF, 5'd4, 32'h44, 32'h18);
    #1;
    check_val("t2_full_allowin", 64'(wb_if.ws_allowin), 64'h0);
    check_val("t2_hold_we",      64'(wb_if.rf_we), 64'hF);
    check_val("t2_hold_waddr",   64'(wb_if.rf_waddr), 64'd1);
    check_val("t2_hold_dbgwen",  64'(debug_wb_rf_wen), 64'h0);
    tick();
    check_val("t2_stable_waddr", 64'(wb_if.rf_waddr), 64'd1);
    check_val("t2_stable_wdata", 64'(wb_if.rf_wdata), 64'h11);
    wb_if.rf_ready = 1'b1;
    #1;
    check_val("t2_pop_allowin", 64'(wb_if.ws_allowin), 64'h1);
    check_val("t2_pc0",         64'(debug_wb_pc), 64'h10);
    check_val("t2_wen0",        64'(debug_wb_rf_wen), 64'hF);
    tick();
    wb_if.ms_to_ws_valid = 1'b0;
    #1;
    check_val("t2_pc1",    64'(debug_wb_pc), 64'h14);
    check_val("t2_waddr1", 64'(wb_if.rf_waddr), 64'd2);
    tick();
    check_val("t2_pc2",    64'(debug_wb_pc), 64'h18);
    check_val("t2_waddr2", 64'(wb_if.rf_waddr), 64'd4);
    tick();
    check_val("t2_empty",  64'(ws_empty), 64'h1);

    // Lane-less entry retires despite rf_ready=0.
    wb_if.rf_ready = 1'b0;
    drive_push(4'h0, 5'd9, 32'h99, 32'h100);
    tick();
    wb_if.ms_to_ws_valid = 1'b0;
    #1;
    check_val("t3_pc",    64'(debug_wb_pc), 64'h100);
    check_val("t3_wen",   64'(debug_wb_rf_wen), 64'h0);
    check_val("t3_rf_we", 64'(wb_if.rf_we), 64'h0);
    check_val("t3_busy",  64'(ws_empty), 64'h0);
    tick();
    check_val("t3_empty", 64'(ws_empty), 64'h1);

    // Hazard query: port0 reads r5, port1 reads r0 (never a hazard).
    id_raddr = {5'd0, 5'd5};
    drive_push(4'hF, 5'd5, 32'h55, 32'h200);
    tick();
    drive_push(4'hF, 5'd0, 32'h0, 32'h204);
    #1 check_val("t4_hit_one", 64'(id_hit), 64'h1);
    tick();
    wb_if.ms_to_ws_valid = 1'b0;
    #1;
    check_val("t4_hit_two",     64'(id_hit), 64'h1);
    check_val("t4_full",        64'(wb_if.ws_allowin), 64'h0);
    wb_if.rf_ready = 1'b1;
    #1;
    check_val("t4_hit_writing", 64'(id_hit), 64'h1);
    check_val("t4_wen",         64'(debug_wb_rf_wen), 64'hF);
    tick();
    check_val("t4_hit_clear",   64'(id_hit), 64'h0);
    check_val("t4_pc_next",     64'(debug_wb_pc), 64'h204);
    tick();
    check_val("t4_empty",       64'(ws_empty), 64'h1);

`ifdef WB_FWD_EN
    // Forwarding: youngest match decides; partial write blocks forwarding.
    wb_if.rf_ready = 1'b0;
    id_raddr = {5'd0, 5'd7};
    drive_push(4'hF, 5'd7, 32'd1, 32'h300);
    tick();
    drive_push(4'h3, 5'd7, 32'd2, 32'h304);
    #1;
    check_val("t5_fwd_ok_full", 64'(id_fwd_ok), 64'h1);
    check_val("t5_fwd_data1",   64'(id_fwd_data[31:0]), 64'd1);
    tick();
    wb_if.ms_to_ws_valid = 1'b0;
    #1;
    check_val("t5_hit_partial", 64'(id_hit), 64'h1);
    check_val("t5_fwd_partial", 64'(id_fwd_ok), 64'h0);
    wb_if.rf_ready = 1'b1;
    drive_push(4'hF, 5'd7, 32'd9, 32'h308);
    #1 check_val("t5_allowin", 64'(wb_if.ws_allowin), 64'h1);
    tick();
    wb_if.rf_ready = 1'b0;
    wb_if.ms_to_ws_valid = 1'b0;
    #1;
    check_val("t5_hit_young",   64'(id_hit), 64'h1);
    check_val("t5_fwd_young",   64'(id_fwd_ok), 64'h1);
    check_val("t5_fwd_data9",   64'(id_fwd_data[31:0]), 64'd9);
    wb_if.rf_ready = 1'b1;
    tick();
    tick();
    check_val("t5_empty", 64'(ws_empty), 64'h1);
`endif

    // Reset mid-stream discards queued entries without any write.
    wb_if.rf_ready = 1'b0;
    id_raddr = {5'd0, 5'd6};
    drive_push(4'hF, 5'd6, 32'h66, 32'h400);
    tick();
    drive_push(4'hF, 5'd6, 32'h67, 32'h404);
    tick();
    wb_if.ms_to_ws_valid = 1'b0;
    #1;
    check_val("t6_pre_busy", 64'(ws_empty), 64'h0);
    check_val("t6_pre_hit",  64'(id_hit), 64'h1);
    resetn = 1'b0;
    #1;
    check_val("t6_rf_we",  64'(wb_if.rf_we), 64'h0);
    check_val("t6_empty",  64'(ws_empty), 64'h1);
    check_val("t6_dbgwen", 64'(debug_wb_rf_wen), 64'h0);
    check_val("t6_hit",    64'(id_hit), 64'h0);
    tick();
    resetn = 1'b1;
    wb_if.rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("t6_post_wen",   64'(debug_wb_rf_wen), 64'h0);
      check_val("t6_post_empty", 64'(ws_empty), 64'h1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
